// File: rtl/rom_burst_arbiter_if.sv
// Bus bundle between the ROM burst arbiter, its two requesters and the ROM.
// The slave modport is the arbiter's view; master is the requester/ROM side.
interface rom_burst_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic                  req_a_i;
  logic [ADDR_WIDTH-1:0] addr_a_i;
  logic [LEN_WIDTH-1:0]  len_a_i;
  logic                  gnt_a_o;
  logic                  rvalid_a_o;
  logic                  rlast_a_o;

  logic                  req_b_i;
  logic [ADDR_WIDTH-1:0] addr_b_i;
  logic [LEN_WIDTH-1:0]  len_b_i;
  logic                  gnt_b_o;
  logic                  rvalid_b_o;
  logic                  rlast_b_o;

  logic [DATA_WIDTH-1:0] rdata_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [DATA_WIDTH-1:0] rom_data_i;

  modport slave (
    input  req_a_i, addr_a_i, len_a_i,
    input  req_b_i, addr_b_i, len_b_i,
    input  rom_data_i,
    output gnt_a_o, rvalid_a_o, rlast_a_o,
    output gnt_b_o, rvalid_b_o, rlast_b_o,
    output rdata_o, rom_addr_o
  );

  modport master (
    output req_a_i, addr_a_i, len_a_i,
    output req_b_i, addr_b_i, len_b_i,
    output rom_data_i,
    input  gnt_a_o, rvalid_a_o, rlast_a_o,
    input  gnt_b_o, rvalid_b_o, rlast_b_o,
    input  rdata_o, rom_addr_o
  );
endinterface

// File: rtl/rom_burst_arbiter.sv
// Two-port round-robin arbiter and burst address sequencer in front of a
// single-port ROM with one-cycle read latency.
module rom_burst_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic             clk_i,
  input logic             rst_ni,
  rom_burst_arbiter_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  state_e                state_r;
  logic                  ptr_r;
  logic                  owner_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  cnt_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic                  rvalid_a_r;
  logic                  rvalid_b_r;
  logic                  rlast_a_r;
  logic                  rlast_b_r;

  logic                  gnt_a_s;
  logic                  gnt_b_s;
  logic                  last_word_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // Grant decode: only in IDLE, gated by reset so no grant shows while held in reset.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (rst_ni && (state_r == IDLE)) begin
      if (bus.req_a_i && (!bus.req_b_i || (ptr_r == OWN_A))) begin
        gnt_a_s = 1'b1;
      end else if (bus.req_b_i) begin
        gnt_b_s = 1'b1;
      end else begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  assign last_word_s = (cnt_r == len_r);

  // Burst FSM: captures the winner, walks addresses and tags the return flags one cycle behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      ptr_r      <= OWN_A;
      owner_r    <= OWN_A;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      cnt_r      <= {LEN_WIDTH{1'b0}};
      len_r      <= {LEN_WIDTH{1'b0}};
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      rlast_a_r  <= 1'b0;
      rlast_b_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_a_r <= 1'b0;
          rvalid_b_r <= 1'b0;
          rlast_a_r  <= 1'b0;
          rlast_b_r  <= 1'b0;
          if (gnt_a_s || gnt_b_s) begin
            state_r <= BURST;
            owner_r <= gnt_b_s ? OWN_B : OWN_A;
            // Pointer hands priority to whoever did not just win.
            ptr_r   <= gnt_a_s ? OWN_B : OWN_A;
            addr_r  <= gnt_b_s ? bus.addr_b_i : bus.addr_a_i;
            len_r   <= gnt_b_s ? bus.len_b_i : bus.len_a_i;
            cnt_r   <= {LEN_WIDTH{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        BURST: begin
          rvalid_a_r <= (owner_r == OWN_A);
          rvalid_b_r <= (owner_r == OWN_B);
          rlast_a_r  <= (owner_r == OWN_A) && last_word_s;
          rlast_b_r  <= (owner_r == OWN_B) && last_word_s;
          if (last_word_s) begin
            state_r <= IDLE;
          end else begin
            addr_r <= addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            cnt_r  <= cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r    <= IDLE;
          rvalid_a_r <= 1'b0;
          rvalid_b_r <= 1'b0;
          rlast_a_r  <= 1'b0;
          rlast_b_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_s        = bus.rom_data_i;
  assign bus.rdata_o    = rdata_s;
  assign bus.rom_addr_o = addr_r;
  assign bus.gnt_a_o    = gnt_a_s;
  assign bus.gnt_b_o    = gnt_b_s;
  assign bus.rvalid_a_o = rvalid_a_r;
  assign bus.rvalid_b_o = rvalid_b_r;
  assign bus.rlast_a_o  = rlast_a_r;
  assign bus.rlast_b_o  = rlast_b_r;
endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter: a cycle-indexed schedule model checks
// every cycle, and the directed scenarios pin key values with literals.
module tb_rom_burst_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk_i;
  logic rst_ni;
  rom_burst_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  rom_burst_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] mem [1024];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ROM with one-cycle read latency
  always @(posedge clk_i) bus.rom_data_i <= mem[bus.rom_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each grant schedules addresses and return words by absolute cycle
  logic [AW-1:0] m_addr [int];
  bit            m_own  [int];
  logic [AW-1:0] m_word [int];
  bit            m_last [int];
  int            m_free = 0;
  bit            m_ptr  = 1'b0;
  logic [AW-1:0] m_last_addr = '0;

  always @(negedge clk_i) begin
    bit idle, ega, egb, erva, ervb, ela, elb;
    int ln;
    logic [AW-1:0] sa;
    cyc++;
    if (!rst_ni) begin
      m_addr.delete(); m_own.delete(); m_word.delete(); m_last.delete();
      m_ptr = 1'b0; m_last_addr = '0; m_free = cyc;
      chk("rst_gnt_a", 32'(bus.gnt_a_o), 32'd0);
      chk("rst_gnt_b", 32'(bus.gnt_b_o), 32'd0);
      chk("rst_rvalid", 32'({bus.rvalid_a_o, bus.rvalid_b_o}), 32'd0);
      chk("rst_rlast", 32'({bus.rlast_a_o, bus.rlast_b_o}), 32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr_o), 32'd0);
    end else begin
      idle = (cyc >= m_free);
      ega  = idle && bus.req_a_i && (!bus.req_b_i || !m_ptr);
      egb  = idle && bus.req_b_i && !ega;
      if (m_addr.exists(cyc)) m_last_addr = m_addr[cyc];
      erva = m_own.exists(cyc) && !m_own[cyc];
      ervb = m_own.exists(cyc) && m_own[cyc];
      ela  = erva && m_last.exists(cyc);
      elb  = ervb && m_last.exists(cyc);
      chk("m_gnt_a", 32'(bus.gnt_a_o), 32'(ega));
      chk("m_gnt_b", 32'(bus.gnt_b_o), 32'(egb));
      chk("m_rom_addr", 32'(bus.rom_addr_o), 32'(m_last_addr));
      chk("m_rvalid_a", 32'(bus.rvalid_a_o), 32'(erva));
      chk("m_rvalid_b", 32'(bus.rvalid_b_o), 32'(ervb));
      chk("m_rlast_a", 32'(bus.rlast_a_o), 32'(ela));
      chk("m_rlast_b", 32'(bus.rlast_b_o), 32'(elb));
      if (erva || ervb) chk("m_rdata", 32'(bus.rdata_o), 32'(mem[m_word[cyc]]));
      if (ega || egb) begin
        sa = ega ? bus.addr_a_i : bus.addr_b_i;
        ln = ega ? int'(bus.len_a_i) : int'(bus.len_b_i);
        for (int k = 0; k <= ln; k++) begin
          m_addr[cyc + 1 + k] = AW'((int'(sa) + k) % 1024);
          m_own[cyc + 2 + k]  = egb;
          m_word[cyc + 2 + k] = AW'((int'(sa) + k) % 1024);
        end
        m_last[cyc + 2 + ln] = 1'b1;
        m_free = cyc + 2 + ln;
        m_ptr  = ega;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for a grant; returns how many cycles after the call it came
  task automatic wait_gnt(input bit who, output int t);
    t = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if ((who ? bus.gnt_b_o : bus.gnt_a_o) === 1'b1) begin
        t = i;
        break;
      end
    end
    chk(who ? "gnt_b_timeout" : "gnt_a_timeout", 32'(t >= 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int gcyc [$];
    bit gwho [$];
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i) ^ 8'hA5;
    rst_ni = 1'b0;
    bus.req_a_i = 1'b0; bus.addr_a_i = '0; bus.len_a_i = '0;
    bus.req_b_i = 1'b0; bus.addr_b_i = '0; bus.len_b_i = '0;
    repeat (3) step();
    @(negedge clk_i);
    chk("reset_rom_addr", 32'(bus.rom_addr_o), 32'd0);
    step();
    rst_ni = 1'b1;
    repeat (2) step();

    // Basic 4-word burst on A
    bus.req_a_i = 1'b1; bus.addr_a_i = 10'h010; bus.len_a_i = 8'd3;
    wait_gnt(1'b0, t);
    chk("t1_gnt_same_cycle", 32'(t), 32'd0);
    step();
    bus.req_a_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      if (c <= 4) chk("t1_addr", 32'(bus.rom_addr_o), 32'h010 + 32'(c - 1));
      chk("t1_rvalid_a", 32'(bus.rvalid_a_o), 32'(c >= 2));
      chk("t1_rlast_a", 32'(bus.rlast_a_o), 32'(c == 5));
      chk("t1_rvalid_b", 32'(bus.rvalid_b_o), 32'd0);
      if (c == 2) chk("t1_rdata0", 32'(bus.rdata_o), 32'h0B5);
    end
    repeat (3) step();

    // Both requesting straight out of reset: A first, then alternating
    rst_ni = 1'b0;
    bus.req_a_i = 1'b1; bus.addr_a_i = 10'h100; bus.len_a_i = 8'd2;
    bus.req_b_i = 1'b1; bus.addr_b_i = 10'h200; bus.len_b_i = 8'd1;
    repeat (2) step();
    rst_ni = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i);
      if (bus.gnt_a_o === 1'b1) begin gcyc.push_back(i); gwho.push_back(1'b0); end
      if (bus.gnt_b_o === 1'b1) begin gcyc.push_back(i); gwho.push_back(1'b1); end
    end
    chk("t2_ngrants", 32'(gcyc.size() >= 4), 32'd1);
    if (gcyc.size() >= 4) begin
      chk("t2_who0", 32'(gwho[0]), 32'd0);
      chk("t2_who1", 32'(gwho[1]), 32'd1);
      chk("t2_who2", 32'(gwho[2]), 32'd0);
      chk("t2_who3", 32'(gwho[3]), 32'd1);
      chk("t2_cyc0", 32'(gcyc[0]), 32'd0);
      chk("t2_cyc1", 32'(gcyc[1]), 32'd4);
      chk("t2_cyc2", 32'(gcyc[2]), 32'd7);
      chk("t2_cyc3", 32'(gcyc[3]), 32'd11);
    end
    step();
    bus.req_a_i = 1'b0; bus.req_b_i = 1'b0;
    repeat (8) step();

    // Address wrap on B
    bus.req_b_i = 1'b1; bus.addr_b_i = 10'h3FE; bus.len_b_i = 8'd3;
    wait_gnt(1'b1, t);
    step();
    bus.req_b_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_i);
      if (c == 1) chk("t3_addr0", 32'(bus.rom_addr_o), 32'h3FE);
      if (c == 2) chk("t3_addr1", 32'(bus.rom_addr_o), 32'h3FF);
      if (c == 3) chk("t3_addr2", 32'(bus.rom_addr_o), 32'h000);
      if (c == 4) chk("t3_addr3", 32'(bus.rom_addr_o), 32'h001);
      if (c >= 2) chk("t3_rvalid_b", 32'(bus.rvalid_b_o), 32'd1);
      chk("t3_rlast_b", 32'(bus.rlast_b_o), 32'(c == 5));
    end
    repeat (3) step();

    // Single-word burst; B waits through it and is granted at A's last word
    bus.req_a_i = 1'b1; bus.addr_a_i = 10'h055; bus.len_a_i = 8'd0;
    wait_gnt(1'b0, t);
    step();
    bus.req_a_i = 1'b0;
    bus.req_b_i = 1'b1; bus.addr_b_i = 10'h056; bus.len_b_i = 8'd0;
    @(negedge clk_i);
    chk("t4_no_gnt_in_burst", 32'(bus.gnt_b_o), 32'd0);
    chk("t4_addr", 32'(bus.rom_addr_o), 32'h055);
    step();
    @(negedge clk_i);
    chk("t4_rvalid_a", 32'(bus.rvalid_a_o), 32'd1);
    chk("t4_rlast_a", 32'(bus.rlast_a_o), 32'd1);
    chk("t4_rdata", 32'(bus.rdata_o), 32'h0F0);
    chk("t4_gnt_b_at_last", 32'(bus.gnt_b_o), 32'd1);
    step();
    bus.req_b_i = 1'b0;
    @(negedge clk_i);
    chk("t4_bubble", 32'(bus.rvalid_a_o | bus.rvalid_b_o), 32'd0);
    chk("t4_addr_b", 32'(bus.rom_addr_o), 32'h056);
    step();
    @(negedge clk_i);
    chk("t4_rv_rl_b", 32'({bus.rvalid_b_o, bus.rlast_b_o}), 32'd3);
    chk("t4_rdata_b", 32'(bus.rdata_o), 32'h0F3);
    repeat (3) step();

    // Reset in the middle of an 8-word burst
    bus.req_a_i = 1'b1; bus.addr_a_i = 10'h080; bus.len_a_i = 8'd7;
    wait_gnt(1'b0, t);
    step();
    bus.req_a_i = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    bus.req_b_i = 1'b1; bus.addr_b_i = 10'h300; bus.len_b_i = 8'd1;
    @(negedge clk_i);
    chk("t5_rst_rvalid_a", 32'(bus.rvalid_a_o), 32'd0);
    chk("t5_rst_gnt_b", 32'(bus.gnt_b_o), 32'd0);
    chk("t5_rst_addr", 32'(bus.rom_addr_o), 32'd0);
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5_gnt_b_after_rst", 32'(bus.gnt_b_o), 32'd1);
    step();
    bus.req_b_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      chk("t5_no_stale_a", 32'(bus.rvalid_a_o), 32'd0);
      if (c == 2) chk("t5_b_rvalid", 32'(bus.rvalid_b_o), 32'd1);
    end
    step();

    // B arrives during A's burst; its addr/len are taken at grant time
    bus.req_a_i = 1'b1; bus.addr_a_i = 10'h020; bus.len_a_i = 8'd4;
    wait_gnt(1'b0, t);
    step();
    bus.req_a_i = 1'b0;
    step();
    bus.req_b_i = 1'b1; bus.addr_b_i = 10'h111; bus.len_b_i = 8'd2;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk_i);
      chk("t6_no_gnt_b", 32'(bus.gnt_b_o), 32'd0);
      step();
      if (c == 3) begin bus.addr_b_i = 10'h140; bus.len_b_i = 8'd1; end
    end
    @(negedge clk_i);
    chk("t6_gnt_b", 32'(bus.gnt_b_o), 32'd1);
    chk("t6_rlast_a", 32'(bus.rlast_a_o), 32'd1);
    step();
    bus.req_b_i = 1'b0;
    @(negedge clk_i);
    chk("t6_b_addr0", 32'(bus.rom_addr_o), 32'h140);
    step();
    @(negedge clk_i);
    chk("t6_b_addr1", 32'(bus.rom_addr_o), 32'h141);
    chk("t6_b_rvalid", 32'(bus.rvalid_b_o), 32'd1);
    step();
    @(negedge clk_i);
    chk("t6_b_rlast", 32'(bus.rlast_b_o), 32'd1);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
